// File: rtl/store_buffer.sv
// Posted-write store buffer: absorbs core stores, drains them oldest-first to memory
// and forwards the youngest buffered data to loads. Optional: STORE_BUFFER_COALESCE_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          mem_wvalid,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wready,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-3:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          st_ready_s;
    logic          mem_wvalid_s;
    logic          push_s;
    logic          pop_s;
    logic          coal_s;
    logic          alloc_s;
    logic          ld_hit_s;
    logic [DW-1:0] ld_data_s;
    logic [PW-1:0] fwd_idx_s;
    logic          unused_s;

    // Readiness and drain validity come from registered occupancy only
    assign st_ready_s   = (count_r != FULL_CNT);
    assign mem_wvalid_s = (count_r != {CW{1'b0}});
    assign unused_s     = ^{st_addr[1:0], ld_addr[1:0]};

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] tail_m1_s;
    assign tail_m1_s = tail_r - PW'(1);
`endif

    // Handshake decode; coalescing never targets the head so mem_w* stays stable
    always_comb begin
        push_s = st_valid & st_ready_s;
        pop_s  = mem_wvalid_s & mem_wready;
`ifdef STORE_BUFFER_COALESCE_EN
        if (push_s && (count_r >= CW'(2)) && (st_addr[AW-1:2] == addr_mem_r[tail_m1_s])) begin
            coal_s = 1'b1;
        end else begin
            coal_s = 1'b0;
        end
`else
        coal_s = 1'b0;
`endif
        alloc_s = push_s & ~coal_s;
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            addr_mem_r[tail_r] <= st_addr[AW-1:2];
            data_mem_r[tail_r] <= st_data;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        else if (coal_s) begin
            data_mem_r[tail_m1_s] <= st_data;
        end
`endif
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (alloc_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({alloc_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match is the last one kept
    always_comb begin
        ld_hit_s  = 1'b0;
        ld_data_s = {DW{1'b0}};
        fwd_idx_s = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = head_r + PW'(i);
            if ((CW'(i) < count_r) && (addr_mem_r[fwd_idx_s] == ld_addr[AW-1:2])) begin
                ld_hit_s  = 1'b1;
                ld_data_s = data_mem_r[fwd_idx_s];
            end else begin
                ld_hit_s  = ld_hit_s;
                ld_data_s = ld_data_s;
            end
        end
    end

    assign st_ready   = st_ready_s;
    assign mem_wvalid = mem_wvalid_s;
    assign mem_waddr  = {addr_mem_r[head_r], 2'b00};
    assign mem_wdata  = data_mem_r[head_r];
    assign ld_hit     = ld_hit_s;
    assign ld_data    = ld_data_s;
    assign count      = count_r;
    assign empty      = ~mem_wvalid_s;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared against a queue-based model of the buffer.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic [2:0]  count;
    logic        empty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];

`ifdef STORE_BUFFER_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wready(mem_wready), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Youngest buffered store to the same word wins; {hit, data}
    function automatic logic [32:0] fwd_lookup(input logic [31:0] a);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr[31:2] == a[31:2]) return {1'b1, q[i].data};
        end
        return 33'd0;
    endfunction

    // Drive one cycle and advance the model with what the buffer saw before the edge
    task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] d, input logic wr);
        bit acc, pp, co;
        st_valid = v; st_addr = a; st_data = d; mem_wready = wr;
        @(posedge clk);
        acc = v && (q.size() != DEPTH);
        pp  = wr && (q.size() != 0);
        co  = acc && COAL && (q.size() >= 2) && (q[q.size()-1].addr[31:2] == a[31:2]);
        if (co) q[q.size()-1].data = d;
        if (pp) void'(q.pop_front());
        if (acc && !co) q.push_back('{addr: a, data: d});
        #1;
    endtask

    task automatic drain_all(input string name);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick(1'b0, 32'd0, 32'd0, 1'b1);
        total++;
        if (empty !== 1'b1 || q.size() != 0) begin
            bad++; $display("FAIL %s_drain: empty=%0b want 1", name, empty);
        end
    endtask

    task automatic test_reset();
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 || mem_wvalid !== 1'b0) begin
            bad++; $display("FAIL reset_state: count=%0d empty=%0b st_ready=%0b wvalid=%0b want 0 1 1 0",
                            count, empty, st_ready, mem_wvalid);
        end
        total++;
        if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin
            bad++; $display("FAIL reset_ld: hit=%0b data=%h want 0 0", ld_hit, ld_data);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        total++;
        if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_present: wvalid=%0b addr=%h data=%h want 1 100 deadbeef",
                            mem_wvalid, mem_waddr, mem_wdata);
        end
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        total++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            bad++; $display("FAIL single_empty: empty=%0b count=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) tick(1'b1, 32'(4 * k), 32'h1000 + 32'(k), 1'b0);
        total++;
        if (count !== 3'd4 || st_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full: count=%0d st_ready=%0b want 4 0", count, st_ready);
        end
        tick(1'b1, 32'h10, 32'hAA, 1'b0);
        total++;
        if (count !== 3'd4 || mem_waddr !== 32'h0) begin
            bad++; $display("FAIL fill_drop: count=%0d head=%h want 4 0", count, mem_waddr);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0);
            total++;
            if (mem_wvalid !== 1'b1 || mem_waddr !== 32'(4 * k) || mem_wdata !== 32'h1000 + 32'(k)) begin
                bad++; $display("FAIL fill_order%0d: addr=%h data=%h want %h %h",
                                k, mem_waddr, mem_wdata, 32'(4 * k), 32'h1000 + 32'(k));
            end
            tick(1'b0, 32'd0, 32'd0, 1'b1);
        end
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL fill_empty: empty=%0b want 1", empty);
        end
    endtask

    task automatic test_full_simul();
        for (int k = 0; k < 4; k++) tick(1'b1, 32'h200 + 32'(4 * k), 32'(k), 1'b0);
        tick(1'b1, 32'h210, 32'h55, 1'b1);
        total++;
        if (count !== 3'd3 || st_ready !== 1'b1 || mem_waddr !== 32'h204) begin
            bad++; $display("FAIL full_simul_pop: count=%0d st_ready=%0b head=%h want 3 1 204",
                            count, st_ready, mem_waddr);
        end
        tick(1'b1, 32'h214, 32'h66, 1'b1);
        total++;
        if (count !== 3'd3 || mem_waddr !== 32'h208) begin
            bad++; $display("FAIL full_simul_pushpop: count=%0d head=%h want 3 208", count, mem_waddr);
        end
        drain_all("full_simul");
    endtask

    task automatic test_forward();
        tick(1'b1, 32'h20, 32'h11, 1'b0);
        tick(1'b1, 32'h24, 32'h22, 1'b0);
        tick(1'b1, 32'h20, 32'h33, 1'b0);
        st_valid = 1'b0;
        ld_addr = 32'h22; #1;
        total++;
        if (ld_hit !== 1'b1 || ld_data !== 32'h33) begin
            bad++; $display("FAIL fwd_hit: hit=%0b data=%h want 1 33", ld_hit, ld_data);
        end
        ld_addr = 32'h28; #1;
        total++;
        if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
            bad++; $display("FAIL fwd_miss: hit=%0b data=%h want 0 0", ld_hit, ld_data);
        end
        // A store entering this cycle must not be forwarded
        st_valid = 1'b1; st_addr = 32'h28; st_data = 32'h77; #1;
        total++;
        if (ld_hit !== 1'b0) begin
            bad++; $display("FAIL fwd_entering: hit=%0b want 0", ld_hit);
        end
        drain_all("forward");
    endtask

    task automatic test_coalesce();
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        int n;
        tick(1'b1, 32'h40, 32'd1, 1'b0);
        tick(1'b1, 32'h44, 32'd2, 1'b0);
        tick(1'b1, 32'h44, 32'd3, 1'b0);
`ifdef STORE_BUFFER_COALESCE_EN
        n = 2; ea[0] = 32'h40; ed[0] = 32'd1; ea[1] = 32'h44; ed[1] = 32'd3;
`else
        n = 3; ea[0] = 32'h40; ed[0] = 32'd1; ea[1] = 32'h44; ed[1] = 32'd2; ea[2] = 32'h44; ed[2] = 32'd3;
`endif
        total++;
        if (count !== 3'(n)) begin
            bad++; $display("FAIL coal_count: count=%0d want %0d", count, n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if (mem_wvalid !== 1'b1 || mem_waddr !== ea[k] || mem_wdata !== ed[k]) begin
                bad++; $display("FAIL coal_drain%0d: addr=%h data=%h want %h %h",
                                k, mem_waddr, mem_wdata, ea[k], ed[k]);
            end
            tick(1'b0, 32'd0, 32'd0, 1'b1);
        end
        drain_all("coalesce");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) tick(1'b1, 32'h300 + 32'(4 * k), 32'(k), 1'b0);
        mem_wready = 1'b1; st_valid = 1'b0;
        #2; reset_n = 1'b0; #1;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || mem_wvalid !== 1'b0 || ld_hit !== 1'b0) begin
            bad++; $display("FAIL reset_mid: count=%0d empty=%0b wvalid=%0b hit=%0b want 0 1 0 0",
                            count, empty, mem_wvalid, ld_hit);
        end
        q.delete();
        @(posedge clk); #2; reset_n = 1'b1; #1;
        total++;
        if (st_ready !== 1'b1 || count !== 3'd0) begin
            bad++; $display("FAIL reset_release: st_ready=%0b count=%0d want 1 0", st_ready, count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [32:0] f;
        for (int c = 0; c < 400; c++) begin
            ld_addr = 32'h1000 + 32'($urandom_range(0, 23));
            st_valid = 1'($urandom_range(0, 1)); st_addr = 32'h1000 + 32'($urandom_range(0, 23));
            st_data = $urandom; mem_wready = ($urandom_range(0, 2) == 0);
            #1;
            f = fwd_lookup(ld_addr);
            total++;
            if (count !== 3'(q.size()) || empty !== (q.size() == 0) || st_ready !== (q.size() != DEPTH)) begin
                bad++; $display("FAIL rand_occ c=%0d: count=%0d empty=%0b ready=%0b want count %0d",
                                c, count, empty, st_ready, q.size());
            end
            total++;
            if (mem_wvalid !== (q.size() != 0) ||
                (q.size() != 0 && (mem_waddr !== {q[0].addr[31:2], 2'b00} || mem_wdata !== q[0].data))) begin
                bad++; $display("FAIL rand_head c=%0d: wvalid=%0b addr=%h data=%h", c, mem_wvalid, mem_waddr, mem_wdata);
            end
            total++;
            if (ld_hit !== f[32] || ld_data !== f[31:0]) begin
                bad++; $display("FAIL rand_fwd c=%0d: hit=%0b data=%h want %0b %h", c, ld_hit, ld_data, f[32], f[31:0]);
            end
            tick(st_valid, st_addr, st_data, mem_wready);
        end
        drain_all("random");
    endtask

    initial begin
        reset_n = 1'b0; st_valid = 1'b0; st_addr = 32'd0; st_data = 32'd0;
        ld_addr = 32'd0; mem_wready = 1'b0;
        #12;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_fill();
        test_full_simul();
        test_forward();
        test_coalesce();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
